// File: rtl/phase_sequencer.sv
// phase_sequencer: GR8RAM bus-phase sequencer. Filters PHI1 on C7M,
// produces bus state S (1..7), refresh slot, DBEN/CSEN strobes and lock status.
// Params: PHI_FILT (1..4) filter depth, REF_DIV (2..16) cycles per refresh slot.
// Ports:  C7M clock, nRES sync active-low reset, PHI1in raw PHI1, nWE 6502 R/W;
//         S, Ref, RefSlot, DBEN, CSEN, PHI0seen, Synced, CycLen, Lost.
// Option: define PHI_WDOG_EN to build the PHI1 watchdog (drives Lost).
module phase_sequencer #(
    parameter int PHI_FILT = 2,
    parameter int REF_DIV  = 13
) (
    input  logic       C7M,
    input  logic       nRES,
    input  logic       PHI1in,
    input  logic       nWE,
    output logic [2:0] S,
    output logic [3:0] Ref,
    output logic       RefSlot,
    output logic       DBEN,
    output logic       CSEN,
    output logic       PHI0seen,
    output logic       Synced,
    output logic [3:0] CycLen,
    output logic       Lost
);
    localparam logic [3:0] REF_LAST = 4'(REF_DIV - 1);

    logic [PHI_FILT-1:0] sh_q, sh_d;
    logic [PHI_FILT:0]   sh_ext;
    logic                phi1f_q, phi1f_d;
    logic                phi1f_dly_q, phi1f_dly_d;
    logic [2:0]          s_q, s_d;
    logic [3:0]          ref_q, ref_d;
    logic                dben_q, dben_d;
    logic                csen_q, csen_d;
    logic                seen_q, seen_d;
    logic                sync_q, sync_d;
    logic                good_q, good_d;
    logic [3:0]          cyc_q, cyc_d;
    logic [4:0]          int_q, int_d;
    logic                rise;
    logic                good_iv;
    logic [5:0]          interval;
`ifdef PHI_WDOG_EN
    logic                lost_q, lost_d;
    logic                wdog;
`endif

    always_comb begin
        // filter: PHI1f only moves when the whole window agrees
        sh_ext = {sh_q, PHI1in};
        sh_d   = sh_ext[PHI_FILT-1:0];
        phi1f_d = phi1f_q;
        if (&sh_q)
            phi1f_d = 1'b1;
        else if (~|sh_q)
            phi1f_d = 1'b0;
        phi1f_dly_d = phi1f_q;

        rise     = phi1f_q & ~phi1f_dly_q & seen_q;
        interval = {1'b0, int_q} + 6'd1;
        good_iv  = (interval == 6'd7) || (interval == 6'd8);

        seen_d = seen_q | ~phi1f_q;
        int_d  = (int_q == 5'd31) ? int_q : int_q + 5'd1;
        cyc_d  = cyc_q;
        sync_d = sync_q;
        good_d = good_q;

        if (rise) begin
            int_d = '0;
            cyc_d = (interval > 6'd15) ? 4'd15 : interval[3:0];
            if (good_iv) begin
                good_d = 1'b1;
                // lock needs two good intervals back to back
                if (good_q)
                    sync_d = 1'b1;
            end else begin
                good_d = 1'b0;
                sync_d = 1'b0;
            end
        end

        if (rise)
            s_d = 3'd1;
        else if (s_q == 3'd0 || s_q == 3'd7)
            s_d = s_q;
        else
            s_d = s_q + 3'd1;

        // uses pre-edge S, so a Rise at S==3 still advances Ref
        ref_d = ref_q;
        if (s_q == 3'd3 && sync_q)
            ref_d = (ref_q == REF_LAST) ? 4'd0 : ref_q + 4'd1;

        dben_d = (s_q >= 3'd4);
        csen_d = ((s_q == 3'd4) && nWE) || (s_q >= 3'd5);

`ifdef PHI_WDOG_EN
        // Rise beats an expiring watchdog
        wdog   = (int_q == 5'd31) && !rise;
        lost_d = lost_q;
        if (rise)
            lost_d = 1'b0;
        else if (wdog)
            lost_d = 1'b1;
        if (wdog) begin
            s_d    = 3'd0;
            sync_d = 1'b0;
            good_d = 1'b0;
            ref_d  = 4'd0;
            // PHI1f low re-earns PHI0seen on the same edge
            seen_d = ~phi1f_q;
        end
`endif
    end

    always_ff @(posedge C7M) begin
        if (!nRES) begin
            sh_q        <= '0;
            phi1f_q     <= 1'b0;
            phi1f_dly_q <= 1'b0;
            s_q         <= '0;
            ref_q       <= '0;
            dben_q      <= 1'b0;
            csen_q      <= 1'b0;
            seen_q      <= 1'b0;
            sync_q      <= 1'b0;
            good_q      <= 1'b0;
            cyc_q       <= '0;
            int_q       <= '0;
        end else begin
            sh_q        <= sh_d;
            phi1f_q     <= phi1f_d;
            phi1f_dly_q <= phi1f_dly_d;
            s_q         <= s_d;
            ref_q       <= ref_d;
            dben_q      <= dben_d;
            csen_q      <= csen_d;
            seen_q      <= seen_d;
            sync_q      <= sync_d;
            good_q      <= good_d;
            cyc_q       <= cyc_d;
            int_q       <= int_d;
        end
    end

`ifdef PHI_WDOG_EN
    always_ff @(posedge C7M) begin
        if (!nRES)
            lost_q <= 1'b0;
        else
            lost_q <= lost_d;
    end
    assign Lost = lost_q;
`else
    assign Lost = 1'b0;
`endif

    assign S        = s_q;
    assign Ref      = ref_q;
    assign RefSlot  = (s_q == 3'd1) && (ref_q == 4'd0) && sync_q;
    assign DBEN     = dben_q;
    assign CSEN     = csen_q;
    assign PHI0seen = seen_q;
    assign Synced   = sync_q;
    assign CycLen   = cyc_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed bench for phase_sequencer (PHI_FILT=2, REF_DIV=13).
// Watchdog expectations follow whether PHI_WDOG_EN is defined.
module tb_phase_sequencer;
    logic       C7M = 1'b0;
    logic       nRES;
    logic       PHI1in;
    logic       nWE;
    logic [2:0] S;
    logic [3:0] Ref;
    logic       RefSlot;
    logic       DBEN;
    logic       CSEN;
    logic       PHI0seen;
    logic       Synced;
    logic [3:0] CycLen;
    logic       Lost;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int refq[$];

    logic [2:0] s_obs    [10];
    logic       dben_obs [10];
    logic       csen_obs [10];
    logic       lost_obs [10];
    logic       syn_end;
    logic [3:0] cl_end;

    int exp_s    [7] = '{5, 6, 7, 1, 2, 3, 4};
    int exp_dben [7] = '{1, 1, 1, 1, 0, 0, 0};
    int exp_csr  [7] = '{1, 1, 1, 1, 0, 0, 0};
    int exp_csw  [7] = '{0, 1, 1, 1, 0, 0, 0};
    int exp_ref  [3] = '{2, 15, 28};

    always #5 C7M = ~C7M;

    phase_sequencer #(.PHI_FILT(2), .REF_DIV(13)) dut (
        .C7M(C7M), .nRES(nRES), .PHI1in(PHI1in), .nWE(nWE),
        .S(S), .Ref(Ref), .RefSlot(RefSlot), .DBEN(DBEN), .CSEN(CSEN),
        .PHI0seen(PHI0seen), .Synced(Synced), .CycLen(CycLen), .Lost(Lost)
    );

    task automatic tick();
        @(posedge C7M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int i);
        s_obs[i]    = S;
        dben_obs[i] = DBEN;
        csen_obs[i] = CSEN;
        lost_obs[i] = Lost;
        if (RefSlot === 1'b1)
            refq.push_back(cyc_n);
    endtask

    // PHI1in high 3 edges, low 'lo' edges; 'gl' = low index carrying a glitch
    task automatic cyc(input int lo, input int gl);
        cyc_n++;
        for (int i = 0; i < 3; i++) begin
            PHI1in = 1'b1;
            tick();
            sample(i);
        end
        for (int i = 0; i < lo; i++) begin
            PHI1in = (i == gl);
            tick();
            sample(3 + i);
        end
        syn_end = Synced;
        cl_end  = CycLen;
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_S"}, S, 0);
        chk({p, "_Ref"}, Ref, 0);
        chk({p, "_RefSlot"}, RefSlot, 0);
        chk({p, "_DBEN"}, DBEN, 0);
        chk({p, "_CSEN"}, CSEN, 0);
        chk({p, "_PHI0seen"}, PHI0seen, 0);
        chk({p, "_Synced"}, Synced, 0);
        chk({p, "_CycLen"}, CycLen, 0);
        chk({p, "_Lost"}, Lost, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        nRES   = 1'b0;
        PHI1in = 1'b0;
        nWE    = 1'b1;
        tick();
        tick();
        chk_zero("rst");
        nRES = 1'b1;
        tick();
        chk("phi0seen_set", PHI0seen, 1);
        tick();
        tick();

        cyc(4, -1);
        chk("c1_s_before", s_obs[2], 0);
        chk("c1_first_s1", s_obs[3], 1);
        chk("c1_synced", syn_end, 0);
        chk("c1_cyclen", cl_end, 7);
        cyc(4, -1);
        chk("c2_synced", syn_end, 1);
        cyc(4, -1);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("c3_s%0d", i), s_obs[i], exp_s[i]);
            chk($sformatf("c3_dben%0d", i), dben_obs[i], exp_dben[i]);
            chk($sformatf("c3_csen_rd%0d", i), csen_obs[i], exp_csr[i]);
        end
        while (cyc_n < 10) cyc(4, -1);
        chk("c10_cyclen", cl_end, 7);
        chk("c10_synced", syn_end, 1);

        cyc(5, -1);
        chk("long_s_tail", s_obs[7], 5);
        cyc(4, -1);
        chk("long_s7a", s_obs[1], 7);
        chk("long_s7b", s_obs[2], 7);
        chk("long_s1", s_obs[3], 1);
        chk("long_cyclen", cl_end, 8);
        chk("long_synced", syn_end, 1);

        cyc(4, 2);
        for (int i = 0; i < 7; i++)
            chk($sformatf("glitch_s%0d", i), s_obs[i], exp_s[i]);
        chk("glitch_cyclen", cl_end, 7);
        chk("glitch_synced", syn_end, 1);
        cyc(4, -1);
        chk("post_glitch_s1", s_obs[3], 1);
        chk("post_glitch_cyclen", cl_end, 7);

        while (cyc_n < 25) cyc(4, -1);
        nWE = 1'b0;
        while (cyc_n < 30) cyc(4, -1);
        for (int i = 0; i < 7; i++)
            chk($sformatf("c30_csen_wr%0d", i), csen_obs[i], exp_csw[i]);
        while (cyc_n < 40) cyc(4, -1);
        chk("refslot_count", refq.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("refslot_cyc%0d", i),
                (refq.size() > i) ? refq[i] : -1, exp_ref[i]);

        PHI1in = 1'b1;
        tick();
        chk("pre_rst_s5", S, 5);
        nRES = 1'b0;
        tick();
        nRES = 1'b1;
        chk_zero("midrst");
        tick();
        chk("midrst_hold_s", S, 0);
        PHI1in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("midrst_low_s%0d", i), S, 0);
        end
        cyc(4, -1);
        chk("resync_s_before", s_obs[2], 0);
        chk("resync_s1", s_obs[3], 1);
        chk("resync_synced_a", syn_end, 0);
        cyc(4, -1);
        chk("resync_synced_b", syn_end, 0);
        cyc(4, -1);
        chk("resync_synced_c", syn_end, 1);

        PHI1in = 1'b1;
        for (int h = 0; h < 40; h++) begin
            tick();
            if (h == 34) begin
                chk("stuck_h34_s", S, 7);
                chk("stuck_h34_lost", Lost, 0);
            end
`ifdef PHI_WDOG_EN
            if (h == 35) begin
                chk("stuck_h35_s", S, 0);
                chk("stuck_h35_lost", Lost, 1);
            end
`endif
        end
`ifdef PHI_WDOG_EN
        chk("stuck_end_s", S, 0);
        chk("stuck_end_lost", Lost, 1);
        chk("stuck_end_synced", Synced, 0);
        chk("stuck_end_phi0seen", PHI0seen, 0);
`else
        chk("stuck_end_s", S, 7);
        chk("stuck_end_lost", Lost, 0);
        chk("stuck_end_synced", Synced, 1);
`endif
        PHI1in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        cyc(4, -1);
`ifdef PHI_WDOG_EN
        chk("resume_s_before", s_obs[2], 0);
        chk("resume_lost_before", lost_obs[2], 1);
`else
        chk("resume_s_before", s_obs[2], 7);
        chk("resume_lost_before", lost_obs[2], 0);
`endif
        chk("resume_s1", s_obs[3], 1);
        chk("resume_lost", lost_obs[3], 0);
        chk("resume_cyclen", cl_end, 15);
        chk("resume_synced_a", syn_end, 0);
        cyc(4, -1);
        chk("resume_synced_b", syn_end, 0);
        cyc(4, -1);
        chk("resume_synced_c", syn_end, 1);
        chk("resume_cyclen_c", cl_end, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Bus-phase sequencer for the GR8RAM CPLD. It samples the Apple II PHI1 clock on C7M and produces the per-cycle state counter S (1..7). It also produces the refresh-slot flag and the registered data-bus and ROM-CS gating strobes. The card-register, RAS/CAS and ROM-select logic downstream consume all of these. It replaces the LCELL delay-chain PHI1 qualification with a deterministic digital filter, and it adds cycle-length and lock reporting.

## Interface

Parameters:
- PHI_FILT, 2: consecutive equal PHI1in samples needed to change the filtered PHI1. Legal range 1..4.
- REF_DIV, 13: number of bus cycles per refresh slot. Legal range 2..16.

Ports:
- C7M  in  1  7.16 MHz clock; all logic runs on its rising edge.
- nRES  in  1  Reset, synchronous, active-low.
- PHI1in  in  1  Raw Apple II PHI1, asynchronous to C7M.
- nWE  in  1  6502 R/W; high means read.
- S  out  3  Bus state: 0 = unsynchronised, 1..7 = C7M edges since PHI1 rise, saturating at 7.
- Ref  out  4  Refresh skip counter, 0..REF_DIV-1.
- RefSlot  out  1  Combinational; equals (S==1 & Ref==0 & Synced).
- DBEN  out  1  Registered data-bus drive enable.
- CSEN  out  1  Registered ROM chip-select enable.
- PHI0seen  out  1  PHI1f has been low at least once since reset.
- Synced  out  1  Cycle lock established.
- CycLen  out  4  C7M edges between the last two accepted PHI1 rises, saturating at 15.
- Lost  out  1  PHI1 watchdog expired. Tied 0 unless PHI_WDOG_EN is defined.

## Operation

Reset:
- nRES is sampled low at a rising edge of C7M.
- At that edge every register clears: filter, PHI1f, PHI1f_d, S, Ref, DBEN, CSEN, PHI0seen, Synced, CycLen, the interval counter, the good-interval count and Lost.
- A reset asserted mid-cycle aborts the cycle. S resynchronises only after PHI1f goes low and then rises again.

Filter:
- Shift register sh[PHI_FILT-1:0] takes PHI1in on every edge.
- PHI1f goes to 1 when sh is all ones and to 0 when sh is all zeros; otherwise it holds.
- PHI1f_d is PHI1f delayed by one edge.

PHI0seen:
- Set on any edge where PHI1f==0.
- Stays set until reset, or until the watchdog fires.

Rise (accepted PHI1 rise):
- Rise = PHI1f & ~PHI1f_d & PHI0seen.

State counter S:
- Rise forces S to 1.
- Otherwise S holds at 0 when S==0, holds at 7 when S==7, and increments in all other cases.

Interval counter:
- IntCnt increments every edge, saturating at 31.
- On Rise, CycLen is loaded with min(IntCnt+1, 15) and IntCnt is cleared.

Lock:
- Synced sets on the second consecutive Rise whose interval is 7 or 8.
- Any Rise with an interval outside 7..8 clears Synced and restarts the good-interval count.

Refresh counter:
- Ref advances on each edge with S==3 and Synced==1. It wraps from REF_DIV-1 to 0.

Data-bus and ROM-CS gating (both update on each rising edge):
- DBEN is loaded with (S>=4).
- CSEN is loaded with ((S==4 & nWE) | S>=5).

## Timing

- Latency: PHI1in sampled high at edge k and held leads to PHI1f=1 after edge k+PHI_FILT and to S=1 after edge k+PHI_FILT+1. With PHI_FILT=2, S becomes 1 three edges after k.
- Glitches: a PHI1in glitch shorter than PHI_FILT edges never changes PHI1f.
- Normal 7-edge cycle: S steps 1,2,3,4,5,6,7, then 1.
- Long 8-edge cycle: S holds at 7 for two edges, then goes to 1.
- DBEN is high for the 4 edges following the S=4..7 states. It drops on the edge after S=1.
- CSEN for a read rises one edge earlier than for a write.
- Simultaneous events:
  - Rise at S==3 with Synced: Ref still advances, because the advance uses the pre-edge S.
  - Rise together with an expiring watchdog: Rise wins and Lost clears.
- PHI1 stuck high with PHI_WDOG_EN undefined: S saturates at 7 indefinitely and Synced is unchanged.

## Configuration

- PHI_WDOG_EN defined:
  - When IntCnt reaches 31, the next edge clears S, Synced, PHI0seen and Ref, and sets Lost.
  - Lost stays high until the next Rise or reset.
  - PHI0seen must be re-earned by PHI1f going low before resynchronisation.
- PHI_WDOG_EN undefined:
  - No watchdog logic is built. Lost is constant 0.
  - IntCnt still saturates at 31 and only feeds CycLen.

## Test plan

- Reset, then 10 cycles of 7-edge PHI1 (PHI1in high for 3 edges and low for 4) with PHI_FILT=2:
  - S reads 1..7 repeating; first S=1 three edges after the first PHI1in high.
  - Synced=1 after the 2nd Rise; CycLen=7.
- An 8-edge long cycle inserted into the steady stream:
  - S=7 for 2 edges; CycLen=8; Synced stays 1.
- 1-edge PHI1in high pulse during PHI0:
  - PHI1f, S and Synced do not change.
- 30 synced cycles with REF_DIV=13 and nWE=1:
  - RefSlot pulses at cycles 1, 14 and 27, one edge wide, at S==1.
  - CSEN rises after the edge with S==4.
  - Repeating with nWE=0, CSEN rises after the edge with S==5.
- nRES low for 1 edge while S==5:
  - All outputs read 0 after that edge.
  - S stays 0 until PHI1f goes low and then rises.
- PHI1in held high for 40 edges with PHI_WDOG_EN defined:
  - Lost=1 and S=0 after IntCnt reaches 31.
  - Normal PHI1 resumes: Lost=0 at the first Rise, Synced=1 after the second good interval.
  - Repeating without the macro: S stays at 7 and Lost stays 0.
